// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, HMASTER/HMASTLOCK handover on HREADY,
// with re-arbitration held off during locked sequences and SEQ/BUSY bursts.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0]             TR_BUSY  = 2'd1;
  localparam logic [1:0]             TR_SEQ   = 2'd3;
  localparam logic [NUM_MASTERS-1:0] PARK_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          PARK_IDX = MW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [MW-1:0]            master_q, master_d;
  logic                     mastlock_q, mastlock_d;

  logic [MW-1:0]            gnt_idx;
  logic [MW-1:0]            winner;
  logic [MW-1:0]            cand_idx;
  logic                     found;
  logic                     hold;
  logic                     arb_en;
  logic                     any_req;
  int                       cand;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gnt_idx = MW'(i);
    end
  end

  assign any_req = |HBUSREQ;
  assign hold    = mastlock_q | (HLOCK[gnt_idx] & HBUSREQ[gnt_idx]) |
                   (HTRANS == TR_SEQ) | (HTRANS == TR_BUSY);
  assign arb_en  = HREADY & ~hold;

  // Scan starts just after the current owner and visits the owner last,
  // so the owner only keeps the bus when nobody else is asking.
  always_comb begin
    winner   = PARK_IDX;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(gnt_idx) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      cand_idx = MW'(cand);
      if (!found && HBUSREQ[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d    = grant_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (arb_en) grant_d = NUM_MASTERS'(1) << winner;
    // Address phase moves to the granted master only when the bus is ready.
    if (HREADY) begin
      master_d   = gnt_idx;
      mastlock_d = HLOCK[gnt_idx] & grant_q[gnt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PARK: begin
        if (mastlock_d)              state_d = ST_LOCKED;
        else if (arb_en && any_req)  state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (mastlock_d)              state_d = ST_LOCKED;
        else if (arb_en && !any_req) state_d = ST_PARK;
      end
      ST_LOCKED: begin
        if (!mastlock_d)             state_d = ST_GRANT;
      end
      default:                       state_d = ST_PARK;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_PARK;
      grant_q    <= PARK_GNT;
      master_q   <= PARK_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
Multi-master AHB-Lite/AHB2 bus arbiter that shares a single AHB slave path between NUM_MASTERS requesters. It sits between the master-side muxes and the decoder/slave mux, and drives the per-master grants, the HMASTER select and HMASTLOCK. Grants use round-robin fairness, with locked-sequence and in-burst hold-off. Grant handover is aligned to HREADY so that address and data phases are never split across owners.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16).
MW, $clog2(NUM_MASTERS), width of HMASTER.
DEFAULT_MASTER, 0, master parked on the bus when nobody requests.

Ports:
HCLK  input  1  bus clock; all logic on the rising edge.
HRESETn  input  1  synchronous active-low reset.
HBUSREQ  input  NUM_MASTERS  per-master bus request.
HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
HTRANS  input  2  muxed HTRANS of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
HREADY  input  1  muxed slave ready; high means the current transfer is completing.
HGRANT  output  NUM_MASTERS  one-hot grant, registered.
HMASTER  output  MW  index of the master owning the address phase, registered.
HMASTLOCK  output  1  current address phase is part of a locked sequence, registered.

Behaviour:
- Reset: when HRESETn=0 at a rising edge, HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, FSM=PARK. Reset mid-transfer drops any lock and burst hold immediately.
- gnt_idx is the encoded index of HGRANT.
- hold = HMASTLOCK | (HLOCK[gnt_idx] & HBUSREQ[gnt_idx]) | (HTRANS==SEQ) | (HTRANS==BUSY).
- arb_en = HREADY & ~hold. HGRANT is recomputed only on edges where arb_en=1; otherwise it is held.
- Winner selection: scan from (gnt_idx+1) mod NUM_MASTERS upward with wrap, including gnt_idx last. The first index with HBUSREQ=1 wins. If there are no requests, the winner is DEFAULT_MASTER.
- Result: the current owner keeps the bus only if no other master requests. With N continuous requesters, each is granted once per N arbitration slots.
- Handover: on every edge with HREADY=1, HMASTER<=gnt_idx and HMASTLOCK<=HLOCK[gnt_idx] & HGRANT[gnt_idx]. When HREADY=0, HMASTER and HMASTLOCK hold.
- Latency: request at edge t (arb_en=1) gives HGRANT at t+1, then HMASTER at the first HREADY=1 edge at or after t+2.
- Lock: while HMASTLOCK=1, no re-arbitration occurs. HMASTLOCK deasserts on the first HREADY=1 edge after the owner drops HLOCK. The next arbitration happens only when HMASTLOCK=0, so the final locked transfer completes before any handover.
- FSM (held in a state register, visible only through the outputs):
  - PARK: DEFAULT_MASTER granted, no requests. Goes to GRANT when any HBUSREQ=1 and arb_en=1.
  - GRANT: a requester owns the grant. Goes to LOCKED when the HMASTLOCK update sets it to 1. Goes to PARK when arb_en=1 and no requests.
  - LOCKED: goes to GRANT when HMASTLOCK clears.
- Simultaneous events: if a new request and the owner's release occur in the same edge, the new request wins via the round-robin scan. A request that appears while HREADY=0 waits. An HLOCK from a master that is not granted is ignored.
- HGRANT is always exactly one-hot, and HMASTER is always less than NUM_MASTERS.
- An X on HBUSREQ/HLOCK under reset is ignored.

Test Plan:
1. Reset with all requests low, then release: HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0, stable for 10 cycles.
2. HBUSREQ=4'b1111 held, HTRANS=NONSEQ, HREADY=1: grants rotate 0→1→2→3→0 on consecutive edges, and HMASTER follows one cycle later.
3. Master 2 granted with HLOCK[2]=1 for 3 transfers while master 1 requests: HMASTLOCK=1 for 3 HREADY cycles, and HGRANT stays 4'b0100 until one edge after HMASTLOCK clears, then becomes 4'b0010.
4. Master 1 bursting (HTRANS=SEQ) with HREADY toggling 1,0,0,1 and master 3 requesting: HGRANT stays 4'b0010 and HMASTER does not change while HREADY=0. Grant moves to 4'b1000 at the first HTRANS=IDLE/NONSEQ edge with HREADY=1.
5. All requests drop while master 3 is granted: HGRANT returns to 4'b0001 (park) on the next arb_en edge, and HMASTER=0 after the next HREADY=1 edge.
6. HRESETn=0 asserted mid-locked-burst (HMASTLOCK=1, HMASTER=2): on the next edge outputs return to their reset values (HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0).
